// File: rtl/pov_spi_rx_if.sv
// SPI pins, frame strobe and point-of-view results of the POV receiver.
// The host side (master) drives the SPI pins and tick; the receiver (slave) drives the results.
interface pov_spi_rx_if #(
  parameter int FW = 16
);
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_csb;
  logic          tick;
  logic [FW-1:0] playerX;
  logic [FW-1:0] playerY;
  logic [FW-1:0] facingX;
  logic [FW-1:0] facingY;
  logic [FW-1:0] vplaneX;
  logic [FW-1:0] vplaneY;
  logic          pending;
  logic          loaded;
  logic          err;

  modport master (
    output spi_sclk, spi_mosi, spi_csb, tick,
    input  playerX, playerY, facingX, facingY, vplaneX, vplaneY,
    input  pending, loaded, err
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_csb, tick,
    output playerX, playerY, facingX, facingY, vplaneX, vplaneY,
    output pending, loaded, err
  );
endinterface

// File: rtl/pov_spi_rx.sv
// SPI mode-0 receiver for the six Q6.10 point-of-view values.
// Completed frames are double-buffered and only reach the live outputs on the frame-start tick.
module pov_spi_rx #(
  parameter int          FW      = 16,
  parameter logic [15:0] PX_INIT = 16'h0600,
  parameter logic [15:0] PY_INIT = 16'h2E00,
  parameter logic [15:0] FX_INIT = 16'h0000,
  parameter logic [15:0] FY_INIT = 16'hFC00,
  parameter logic [15:0] VX_INIT = 16'h0200,
  parameter logic [15:0] VY_INIT = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  pov_spi_rx_if.slave  bus
);
  localparam int NB = 6 * FW;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, FULL, OVER, COMMIT} state_t;

  logic          r_sclkMeta, r_sclkSync, r_sclkPrev;
  logic          r_mosiMeta, r_mosiSync;
  logic          r_csbMeta,  r_csbSync,  r_csbPrev;
  logic          w_sclkRise, w_csbRise;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          w_shift, w_cntClr, w_commit, w_errSet, w_apply;

  logic [NB-1:0] r_sr;
  logic [NB-1:0] r_pendBuf;
  logic [NB-1:0] r_live;
  logic          r_pending, r_loaded, r_err;

  // The chip-select stages reset high so a held-low CSB looks like a fresh frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclkMeta <= 1'b0;
      r_sclkSync <= 1'b0;
      r_sclkPrev <= 1'b0;
      r_mosiMeta <= 1'b0;
      r_mosiSync <= 1'b0;
      r_csbMeta  <= 1'b1;
      r_csbSync  <= 1'b1;
      r_csbPrev  <= 1'b1;
    end else begin
      r_sclkMeta <= bus.spi_sclk;
      r_sclkSync <= r_sclkMeta;
      r_sclkPrev <= r_sclkSync;
      r_mosiMeta <= bus.spi_mosi;
      r_mosiSync <= r_mosiMeta;
      r_csbMeta  <= bus.spi_csb;
      r_csbSync  <= r_csbMeta;
      r_csbPrev  <= r_csbSync;
    end
  end

  assign w_sclkRise = r_sclkSync & ~r_sclkPrev;
  assign w_csbRise  = r_csbSync & ~r_csbPrev;

  always_comb begin
    w_next   = r_state;
    w_shift  = 1'b0;
    w_cntClr = 1'b0;
    w_commit = 1'b0;
    w_errSet = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_csbSync) begin
          w_cntClr = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_csbRise) begin
          w_errSet = 1'b1;
          w_next   = IDLE;
        end else if (w_sclkRise) begin
          w_shift = 1'b1;
          if (r_cnt == CW'(NB - 1)) w_next = FULL;
        end
      end
      FULL: begin
        if (w_csbRise)       w_next = COMMIT;
        else if (w_sclkRise) w_next = OVER;
      end
      OVER: begin
        if (w_csbRise) begin
          w_errSet = 1'b1;
          w_next   = IDLE;
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_apply = bus.tick & r_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
      r_live    <= {PX_INIT, PY_INIT, FX_INIT, FY_INIT, VX_INIT, VY_INIT};
    end else begin
      r_state  <= w_next;
      r_err    <= w_errSet;
      r_loaded <= w_apply;
      if (w_cntClr)     r_cnt <= '0;
      else if (w_shift) r_cnt <= r_cnt + CW'(1);
      // A commit landing on the tick cycle keeps the new frame pending for the next tick.
      if (w_commit)     r_pending <= 1'b1;
      else if (w_apply) r_pending <= 1'b0;
      if (w_apply)      r_live <= r_pendBuf;
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift)  r_sr      <= {r_sr[NB-2:0], r_mosiSync};
    if (w_commit) r_pendBuf <= r_sr;
  end

  assign bus.playerX = r_live[6*FW-1 -: FW];
  assign bus.playerY = r_live[5*FW-1 -: FW];
  assign bus.facingX = r_live[4*FW-1 -: FW];
  assign bus.facingY = r_live[3*FW-1 -: FW];
  assign bus.vplaneX = r_live[2*FW-1 -: FW];
  assign bus.vplaneY = r_live[FW-1 -: FW];
  assign bus.pending = r_pending;
  assign bus.loaded  = r_loaded;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_pov_spi_rx.sv
// Directed bench for pov_spi_rx: a table of whole frames plus hand-written overwrite,
// tick/commit collision and mid-transfer reset sequences.
module tb_pov_spi_rx;
  localparam logic [95:0] INIT  = {16'h0600, 16'h2E00, 16'h0000, 16'hFC00, 16'h0200, 16'h0000};
  localparam logic [95:0] GOOD0 = {16'h0A00, 16'h1400, 16'h0400, 16'h0000, 16'h0000, 16'h0200};
  localparam logic [95:0] GOOD1 = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0};
  localparam logic [95:0] JUNK  = {16'hAAAA, 16'h5555, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF};
  localparam logic [95:0] FRA   = {16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
  localparam logic [95:0] FRB   = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
  localparam logic [95:0] FRC   = {16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC006};
  localparam logic [95:0] FRE   = {16'hE0E0, 16'h0E0E, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1357};

  typedef struct {
    logic [95:0] payload;
    int          nBits;
    int          expErr;
    logic        expPend;
    logic [95:0] expLive;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   errCycles;
  int   loadCycles;
  logic [95:0] curLive;

  pov_spi_rx_if #(.FW(16)) bus ();

  pov_spi_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.err)    errCycles  = errCycles + 1;
    if (bus.loaded) loadCycles = loadCycles + 1;
  end

  function automatic logic [95:0] liveNow();
    return {bus.playerX, bus.playerY, bus.facingX, bus.facingY, bus.vplaneX, bus.vplaneY};
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bits first..last of the payload, MSB first; positions past 95 send a 1.
  task automatic shiftBits(input logic [95:0] payload, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.spi_mosi = (i < 96) ? payload[95 - i] : 1'b1;
      waitClocks(4);
      bus.spi_sclk = 1'b1;
      waitClocks(4);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [95:0] payload, input int nBits);
    @(negedge clk);
    bus.spi_csb = 1'b0;
    waitClocks(4);
    shiftBits(payload, 0, nBits - 1);
    waitClocks(4);
    bus.spi_csb = 1'b1;
    waitClocks(8);
  endtask

  task automatic pulseTick();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int   errBase;
    int   loadBase;

    vecs[0] = '{GOOD0, 96, 0, 1'b1, GOOD0};
    vecs[1] = '{JUNK,  95, 1, 1'b0, GOOD0};
    vecs[2] = '{JUNK,  97, 1, 1'b0, GOOD0};
    vecs[3] = '{GOOD1, 96, 0, 1'b1, GOOD1};

    checks     = 0;
    errors     = 0;
    errCycles  = 0;
    loadCycles = 0;
    reset        = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_csb  = 1'b1;
    bus.tick     = 1'b0;

    waitClocks(5);
    checkOutput("reset_live", liveNow(), INIT);
    checkOutput("reset_pending", 96'(bus.pending), 96'd0);
    checkOutput("reset_loaded", 96'(bus.loaded), 96'd0);
    checkOutput("reset_err", 96'(bus.err), 96'd0);
    reset = 1'b1;
    waitClocks(3);
    checkOutput("released_live", liveNow(), INIT);
    curLive = INIT;

    for (int v = 0; v < 4; v++) begin
      errBase  = errCycles;
      applyStimulus(vecs[v].payload, vecs[v].nBits);
      checkOutput($sformatf("v%0d_err", v), 96'(errCycles - errBase), 96'(vecs[v].expErr));
      checkOutput($sformatf("v%0d_pending", v), 96'(bus.pending), 96'(vecs[v].expPend));
      checkOutput($sformatf("v%0d_hold", v), liveNow(), curLive);
      loadBase = loadCycles;
      pulseTick();
      checkOutput($sformatf("v%0d_loaded", v), 96'(bus.loaded), 96'(vecs[v].expPend));
      waitClocks(2);
      checkOutput($sformatf("v%0d_live", v), liveNow(), vecs[v].expLive);
      checkOutput($sformatf("v%0d_loadcnt", v), 96'(loadCycles - loadBase), 96'(vecs[v].expPend));
      checkOutput($sformatf("v%0d_pend_after", v), 96'(bus.pending), 96'd0);
      curLive = vecs[v].expLive;
    end

    // Latest frame wins when two arrive before a tick.
    applyStimulus(FRA, 96);
    applyStimulus(FRB, 96);
    checkOutput("ovr_pending", 96'(bus.pending), 96'd1);
    checkOutput("ovr_hold", liveNow(), curLive);
    loadBase = loadCycles;
    pulseTick();
    waitClocks(2);
    checkOutput("ovr_live", liveNow(), FRB);
    checkOutput("ovr_loadcnt", 96'(loadCycles - loadBase), 96'd1);

    // Tick sampled on the same edge that commits frame C while B is still pending.
    applyStimulus(FRB, 96);
    @(negedge clk);
    bus.spi_csb = 1'b0;
    waitClocks(4);
    shiftBits(FRC, 0, 95);
    waitClocks(4);
    bus.spi_csb = 1'b1;
    waitClocks(3);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    checkOutput("col_loaded", 96'(bus.loaded), 96'd1);
    checkOutput("col_live", liveNow(), FRB);
    checkOutput("col_pending", 96'(bus.pending), 96'd1);
    waitClocks(4);
    pulseTick();
    waitClocks(2);
    checkOutput("col_live2", liveNow(), FRC);
    checkOutput("col_pending2", 96'(bus.pending), 96'd0);

    // Reset 40 bits into a frame while another frame is pending.
    applyStimulus(FRA, 96);
    checkOutput("mrst_pend_before", 96'(bus.pending), 96'd1);
    @(negedge clk);
    bus.spi_csb = 1'b0;
    waitClocks(4);
    shiftBits(FRE, 0, 39);
    @(negedge clk);
    reset = 1'b0;
    waitClocks(2);
    checkOutput("mrst_live", liveNow(), INIT);
    checkOutput("mrst_pending", 96'(bus.pending), 96'd0);
    reset = 1'b1;
    errBase = errCycles;
    waitClocks(2);
    shiftBits(FRE, 40, 95);
    waitClocks(4);
    bus.spi_csb = 1'b1;
    waitClocks(8);
    checkOutput("mrst_err", 96'(errCycles - errBase), 96'd1);
    checkOutput("mrst_pending2", 96'(bus.pending), 96'd0);
    loadBase = loadCycles;
    pulseTick();
    waitClocks(2);
    checkOutput("mrst_live2", liveNow(), INIT);
    checkOutput("mrst_loadcnt", 96'(loadCycles - loadBase), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
